// File: rtl/record_viewer.sv
// Lap-record ring buffer with push-button paging for the stopwatch display path.
// Optional feature: RECORD_WRAP_EN makes writes when full overwrite the oldest record.
module record_viewer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             iRecValid,
  input  logic [23:0]      iRecTime,
  input  logic             iClr,
  input  logic             fView,
  input  logic             fPrev,
  input  logic             fNext,
  output logic [23:0]      oTime,
  output logic [IDX_W:0]   oIndex,
  output logic [IDX_W:0]   oCount,
  output logic             oViewing,
  output logic             oFull
);

  typedef enum logic [0:0] {StIdle, StView} state_e;

  localparam logic [IDX_W-1:0] PtrOne  = IDX_W'(1);
  localparam logic [IDX_W:0]   CntFull = (IDX_W + 1)'(DEPTH);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] wp_q, wp_d, op_q, op_d, rp_q, rp_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic             view_q, prev_q, next_q;
  logic             view_press, prev_press, next_press;
  logic [IDX_W-1:0] newest;
  logic             we;
  logic [23:0]      mem_q [DEPTH];
  logic [23:0]      time_q;
  logic [IDX_W:0]   index_q;
  logic             viewing_q;

  // A press is a released-to-pressed transition between the last sample and now.
  assign view_press = view_q & ~fView;
  assign prev_press = prev_q & ~fPrev;
  assign next_press = next_q & ~fNext;
  assign newest     = wp_q - PtrOne;

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    op_d    = op_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    if (iClr) begin
      state_d = StIdle;
      wp_d    = '0;
      op_d    = '0;
      rp_d    = '0;
      cnt_d   = '0;
    end else begin
      if (view_press) begin
        if (state_q == StView) begin
          state_d = StIdle;
        end else if (cnt_q != '0) begin
          state_d = StView;
          rp_d    = newest;
        end
      end else if (prev_press && state_q == StView) begin
        if (rp_q != op_q) rp_d = rp_q - PtrOne;
      end else if (next_press && state_q == StView) begin
        if (rp_q != newest) rp_d = rp_q + PtrOne;
      end

      if (iRecValid) begin
        if (cnt_q != CntFull) begin
          we    = 1'b1;
          wp_d  = wp_q + PtrOne;
          cnt_d = cnt_q + 1'b1;
        end else begin
`ifdef RECORD_WRAP_EN
          we   = 1'b1;
          wp_d = wp_q + PtrOne;
          op_d = op_q + PtrOne;
          // A view parked on the oldest record follows it as it is overwritten.
          if (rp_d == op_q) rp_d = op_q + PtrOne;
`endif
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q   <= StIdle;
      wp_q      <= '0;
      op_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      view_q    <= 1'b1;
      prev_q    <= 1'b1;
      next_q    <= 1'b1;
      time_q    <= '0;
      index_q   <= '0;
      viewing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wp_q      <= wp_d;
      op_q      <= op_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      view_q    <= fView;
      prev_q    <= fPrev;
      next_q    <= fNext;
      viewing_q <= (state_q == StView);
      if (state_q == StView) begin
        time_q  <= mem_q[rp_q];
        index_q <= {1'b0, rp_q - op_q} + 1'b1;
      end else begin
        time_q  <= '0;
        index_q <= '0;
      end
    end
  end

  // Record storage carries no reset; cnt/pointers define which entries are valid.
  always_ff @(posedge Clk) begin
    if (Rst && we) mem_q[wp_q] <= iRecTime;
  end

  assign oTime    = time_q;
  assign oIndex   = index_q;
  assign oCount   = cnt_q;
  assign oViewing = viewing_q;
  assign oFull    = (cnt_q == CntFull);

endmodule

// File: tb/tb_record_viewer.sv
// Directed self-checking bench for record_viewer (DEPTH=8); expectations follow RECORD_WRAP_EN.
module tb_record_viewer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        iRecValid;
  logic [23:0] iRecTime;
  logic        iClr;
  logic        fView, fPrev, fNext;
  logic [23:0] oTime;
  logic [3:0]  oIndex;
  logic [3:0]  oCount;
  logic        oViewing;
  logic        oFull;

  int checks = 0;
  int errors = 0;

  record_viewer #(.DEPTH(8), .IDX_W(3)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .iRecValid (iRecValid),
    .iRecTime  (iRecTime),
    .iClr      (iClr),
    .fView     (fView),
    .fPrev     (fPrev),
    .fNext     (fNext),
    .oTime     (oTime),
    .oIndex    (oIndex),
    .oCount    (oCount),
    .oViewing  (oViewing),
    .oFull     (oFull)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic write(input logic [23:0] val);
    iRecValid = 1'b1;
    iRecTime  = val;
    step(1);
    iRecValid = 1'b0;
  endtask

  // which: 0=view 1=prev 2=next; returns once the registered outputs reflect the press
  task automatic press(input int which);
    if (which == 0) fView = 1'b0;
    else if (which == 1) fPrev = 1'b0;
    else fNext = 1'b0;
    step(1);
    fView = 1'b1;
    fPrev = 1'b1;
    fNext = 1'b1;
    step(1);
  endtask

  initial begin
    logic [23:0] exp_old, exp_new;
`ifdef RECORD_WRAP_EN
    exp_old = 24'h000002;
    exp_new = 24'h000009;
`else
    exp_old = 24'h000001;
    exp_new = 24'h000008;
`endif
    Rst = 1'b0; iRecValid = 1'b0; iRecTime = '0; iClr = 1'b0;
    fView = 1'b1; fPrev = 1'b1; fNext = 1'b1;
    step(2);
    Rst = 1'b1;
    step(1);
    check("rst_time",    32'(oTime),    32'h0);
    check("rst_index",   32'(oIndex),   32'h0);
    check("rst_count",   32'(oCount),   32'h0);
    check("rst_viewing", 32'(oViewing), 32'h0);
    check("rst_full",    32'(oFull),    32'h0);

    press(0);
    step(1);
    check("empty_view_viewing", 32'(oViewing), 32'h0);
    check("empty_view_time",    32'(oTime),    32'h0);
    check("empty_view_count",   32'(oCount),   32'h0);

    write(24'h000111);
    write(24'h000222);
    write(24'h000333);
    check("count3", 32'(oCount), 32'd3);
    press(0);
    check("view_viewing", 32'(oViewing), 32'h1);
    check("view_index",   32'(oIndex),   32'd3);
    check("view_time",    32'(oTime),    32'h000333);
    press(1);
    press(1);
    check("prev2_index", 32'(oIndex), 32'd1);
    check("prev2_time",  32'(oTime),  32'h000111);
    press(1);
    check("prev_sat_index", 32'(oIndex), 32'd1);
    check("prev_sat_time",  32'(oTime),  32'h000111);

    fNext = 1'b0;
    #1000;
    fNext = 1'b1;
    step(2);
    check("hold_next_index", 32'(oIndex), 32'd2);
    check("hold_next_time",  32'(oTime),  32'h000222);

    // Write and navigate in the same cycle.
    iRecValid = 1'b1; iRecTime = 24'h001000; fNext = 1'b0;
    step(1);
    iRecValid = 1'b0; fNext = 1'b1;
    step(1);
    check("wn_count", 32'(oCount), 32'd4);
    check("wn_index", 32'(oIndex), 32'd3);
    check("wn_time",  32'(oTime),  32'h000333);
    press(2);
    check("wn_next_index", 32'(oIndex), 32'd4);
    check("wn_next_time",  32'(oTime),  32'h001000);

    // Clear beats a simultaneous write and view press.
    iClr = 1'b1; iRecValid = 1'b1; iRecTime = 24'h00abcd; fView = 1'b0;
    step(1);
    iClr = 1'b0; iRecValid = 1'b0; fView = 1'b1;
    step(1);
    check("clr_count",   32'(oCount),   32'd0);
    check("clr_viewing", 32'(oViewing), 32'h0);
    check("clr_time",    32'(oTime),    32'h0);
    check("clr_index",   32'(oIndex),   32'h0);

    for (int i = 1; i <= 9; i++) write(24'(i));
    check("full_count", 32'(oCount), 32'd8);
    check("full_flag",  32'(oFull),  32'h1);
    press(0);
    check("full_newest_index", 32'(oIndex), 32'd8);
    check("full_newest_time",  32'(oTime),  32'(exp_new));
    for (int i = 0; i < 7; i++) press(1);
    check("full_oldest_index", 32'(oIndex), 32'd1);
    check("full_oldest_time",  32'(oTime),  32'(exp_old));

    // Reset for a single edge while viewing.
    Rst = 1'b0;
    step(1);
    Rst = 1'b1;
    check("mid_rst_viewing", 32'(oViewing), 32'h0);
    check("mid_rst_time",    32'(oTime),    32'h0);
    check("mid_rst_index",   32'(oIndex),   32'h0);
    check("mid_rst_count",   32'(oCount),   32'h0);
    check("mid_rst_full",    32'(oFull),    32'h0);
    press(0);
    step(1);
    check("post_rst_view_viewing", 32'(oViewing), 32'h0);
    check("post_rst_view_time",    32'(oTime),    32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
